// File: rtl/pattern_game_manager.sv
// -----------------------------------------------------------------------------
// pattern_game_manager
// Controller for an 8-button memory game. It holds the game FSM, the 16-bit
// LFSR pattern generator, keypad/button rising-edge detection and LED drive.
//
// Optional build macro: INPUT_ECHO_EN
//   defined   - each accepted press in INPUT lights that button's LED for
//               STEP_ON_CYCLES/4 cycles, or until the next accepted press
//   undefined - LEDs stay dark throughout INPUT
//   FSM timing is the same in both builds.
//
// Ports:
//   clk_2               system clock, rising edge
//   rst                 synchronous active-high reset
//   botton_1..botton_8  player buttons, active-high, synchronous to clk_2
//   KEY_COL[2:0]        keypad columns, active-high
//   KEY_ROW[3:0]        keypad rows, active-high
//   led_1..led_7        LEDs 1-7 (registered)
//   led_8_s             LED 8 (registered)
// -----------------------------------------------------------------------------
module pattern_game_manager #(
    parameter int unsigned STEP_ON_CYCLES  = 8192,
    parameter int unsigned STEP_OFF_CYCLES = 8192,
    parameter int unsigned RESULT_CYCLES   = 4096,
    parameter int unsigned MAX_ROUNDS      = 20,
    parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
    input  logic       clk_2,
    input  logic       rst,
    input  logic       botton_1,
    input  logic       botton_2,
    input  logic       botton_3,
    input  logic       botton_4,
    input  logic       botton_5,
    input  logic       botton_6,
    input  logic       botton_7,
    input  logic       botton_8,
    input  logic [2:0] KEY_COL,
    input  logic [3:0] KEY_ROW,
    output logic       led_1,
    output logic       led_2,
    output logic       led_3,
    output logic       led_4,
    output logic       led_5,
    output logic       led_6,
    output logic       led_7,
    output logic       led_8_s
);

    localparam int unsigned MAX_LEN   = 16;
    localparam int unsigned IDX_W     = 4;
    localparam int unsigned T_MAX_A   = (STEP_ON_CYCLES > STEP_OFF_CYCLES) ? STEP_ON_CYCLES : STEP_OFF_CYCLES;
    localparam int unsigned T_MAX     = (T_MAX_A > RESULT_CYCLES) ? T_MAX_A : RESULT_CYCLES;
    localparam int unsigned TMR_W     = $clog2(T_MAX + 1);
    localparam int unsigned ROUND_W   = $clog2(MAX_ROUNDS + 1);
    localparam int unsigned QUARTER   = (RESULT_CYCLES / 4 > 0) ? RESULT_CYCLES / 4 : 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SELECT,
        ST_GEN,
        ST_SHOW,
        ST_INPUT,
        ST_WIN_RND,
        ST_FAIL,
        ST_DONE
    } state_t;

    function automatic logic [7:0] onehot8(input logic [2:0] i);
        onehot8 = 8'd1 << i;
    endfunction

    state_t             state;
    logic [15:0]        lfsr;
    logic [2:0]         pattern [MAX_LEN];
    logic [IDX_W-1:0]   idx;
    logic [1:0]         level;
    logic [ROUND_W-1:0] round;
    logic [TMR_W-1:0]   tmr;
    logic [TMR_W-1:0]   qtmr;
    logic               show_off;
    logic               blink_odd;
    logic [7:0]         btn_prev;
    logic [2:0]         key_prev;
    logic [7:0]         leds;

    logic [7:0]         btn_c;
    logic [7:0]         btn_rise_c;
    logic [2:0]         key_now_c;
    logic [2:0]         key_rise_c;
    logic               single_c;
    logic               accept_c;
    logic [4:0]         pat_len_c;
    logic [IDX_W-1:0]   last_idx_c;
    logic               lfsr_fb_c;
    logic [7:0]         echo_leds_c;
    logic               unused_key_rows_c;

    assign btn_c = {botton_8, botton_7, botton_6, botton_5,
                    botton_4, botton_3, botton_2, botton_1};
    assign btn_rise_c = btn_c & ~btn_prev;

    // Only row-0 keys have a function; the other rows are decoded away.
    assign key_now_c         = {3{KEY_ROW[0]}} & KEY_COL;
    assign key_rise_c        = key_now_c & ~key_prev;
    assign unused_key_rows_c = ^KEY_ROW[3:1];

    // Exactly one button edge this cycle.
    assign single_c  = (btn_rise_c != 8'h00) && ((btn_rise_c & (btn_rise_c - 8'd1)) == 8'h00);
    assign accept_c  = (state == ST_INPUT) && single_c && (btn_rise_c == onehot8(pattern[idx]));

    // Pattern length 8/12/16 for level 1/2/3.
    assign pat_len_c  = {1'b0, level, 2'b00} + 5'd4;
    assign last_idx_c = IDX_W'(pat_len_c - 5'd1);

    // Fibonacci taps 16,14,13,11.
    assign lfsr_fb_c = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

`ifdef INPUT_ECHO_EN
    localparam int unsigned ECHO_CYCLES = (STEP_ON_CYCLES / 4 > 0) ? STEP_ON_CYCLES / 4 : 1;

    logic             echo_on;
    logic [2:0]       echo_idx;
    logic [TMR_W-1:0] echo_tmr;

    // Echo of the last accepted press; a new press restarts it.
    always_ff @(posedge clk_2) begin
        if (rst) begin
            echo_on  <= 1'b0;
            echo_idx <= 3'd0;
            echo_tmr <= '0;
        end else if (state != ST_INPUT) begin
            echo_on  <= 1'b0;
        end else if (accept_c) begin
            echo_on  <= 1'b1;
            echo_idx <= pattern[idx];
            echo_tmr <= '0;
        end else if (echo_on) begin
            if (echo_tmr == TMR_W'(ECHO_CYCLES - 1)) echo_on <= 1'b0;
            else                                     echo_tmr <= echo_tmr + 1'b1;
        end
    end

    assign echo_leds_c = echo_on ? onehot8(echo_idx) : 8'h00;
`else
    assign echo_leds_c = 8'h00;
`endif

    // Game FSM, LFSR, edge history and registered LED drive.
    always_ff @(posedge clk_2) begin
        if (rst) begin
            state     <= ST_IDLE;
            lfsr      <= LFSR_SEED;
            idx       <= '0;
            level     <= 2'd0;
            round     <= '0;
            tmr       <= '0;
            qtmr      <= '0;
            show_off  <= 1'b0;
            blink_odd <= 1'b0;
            btn_prev  <= 8'h00;
            key_prev  <= 3'b000;
            leds      <= 8'h00;
        end else begin
            lfsr     <= {lfsr[14:0], lfsr_fb_c};
            btn_prev <= btn_c;
            key_prev <= key_now_c;

            case (state)
                ST_IDLE: begin
                    leds <= 8'h00;
                    if (key_rise_c[0]) state <= ST_SELECT;
                end

                ST_SELECT: begin
                    leds <= 8'h07;
                    if (key_rise_c != 3'b000) begin
                        if (key_rise_c[0])      level <= 2'd1;
                        else if (key_rise_c[1]) level <= 2'd2;
                        else                    level <= 2'd3;
                        round <= round + 1'b1;
                        idx   <= '0;
                        state <= ST_GEN;
                    end
                end

                // One pattern entry per cycle from the free-running LFSR.
                ST_GEN: begin
                    leds         <= 8'h00;
                    pattern[idx] <= lfsr[2:0];
                    if (idx == last_idx_c) begin
                        idx      <= '0;
                        tmr      <= '0;
                        show_off <= 1'b0;
                        state    <= ST_SHOW;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end

                ST_SHOW: begin
                    leds <= show_off ? 8'h00 : onehot8(pattern[idx]);
                    if (!show_off) begin
                        if (tmr == TMR_W'(STEP_ON_CYCLES - 1)) begin
                            tmr      <= '0;
                            show_off <= 1'b1;
                        end else begin
                            tmr <= tmr + 1'b1;
                        end
                    end else if (tmr == TMR_W'(STEP_OFF_CYCLES - 1)) begin
                        tmr      <= '0;
                        show_off <= 1'b0;
                        if (idx == last_idx_c) begin
                            idx   <= '0;
                            state <= ST_INPUT;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end else begin
                        tmr <= tmr + 1'b1;
                    end
                end

                ST_INPUT: begin
                    leds <= echo_leds_c;
                    if (btn_rise_c != 8'h00) begin
                        if (accept_c) begin
                            if (idx == last_idx_c) begin
                                tmr   <= '0;
                                state <= ST_WIN_RND;
                            end else begin
                                idx <= idx + 1'b1;
                            end
                        end else begin
                            tmr       <= '0;
                            qtmr      <= '0;
                            blink_odd <= 1'b0;
                            state     <= ST_FAIL;
                        end
                    end
                end

                ST_WIN_RND: begin
                    leds <= 8'hFF;
                    if (tmr == TMR_W'(RESULT_CYCLES - 1)) begin
                        tmr <= '0;
                        idx <= '0;
                        if (round < ROUND_W'(MAX_ROUNDS)) begin
                            round <= round + 1'b1;
                            state <= ST_GEN;
                        end else begin
                            state <= ST_DONE;
                        end
                    end else begin
                        tmr <= tmr + 1'b1;
                    end
                end

                // 0x55/0xAA alternating every quarter of the result window.
                ST_FAIL: begin
                    leds <= blink_odd ? 8'hAA : 8'h55;
                    if (qtmr == TMR_W'(QUARTER - 1)) begin
                        qtmr      <= '0;
                        blink_odd <= ~blink_odd;
                    end else begin
                        qtmr <= qtmr + 1'b1;
                    end
                    if (tmr == TMR_W'(RESULT_CYCLES - 1)) begin
                        tmr   <= '0;
                        round <= '0;
                        state <= ST_IDLE;
                    end else begin
                        tmr <= tmr + 1'b1;
                    end
                end

                ST_DONE: begin
                    leds <= 8'hFF;
                    if (key_rise_c[0]) begin
                        round <= '0;
                        state <= ST_SELECT;
                    end
                end

                default: begin
                    leds  <= 8'h00;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign led_1   = leds[0];
    assign led_2   = leds[1];
    assign led_3   = leds[2];
    assign led_4   = leds[3];
    assign led_5   = leds[4];
    assign led_6   = leds[5];
    assign led_7   = leds[6];
    assign led_8_s = leds[7];

endmodule

// File: tb/tb_pattern_game_manager.sv
// -----------------------------------------------------------------------------
// tb_pattern_game_manager
// Self-checking bench for pattern_game_manager with shortened timing.
// A reference LFSR (shift in the parity of the tapped bits) runs alongside the
// design; patterns are predicted from it and the LEDs are checked every cycle.
// -----------------------------------------------------------------------------
module tb_pattern_game_manager;

    localparam int unsigned ON   = 8;
    localparam int unsigned OFF  = 4;
    localparam int unsigned RES  = 16;
    localparam int unsigned MAXR = 3;
    localparam int unsigned Q    = RES / 4;
    localparam logic [15:0] SEED = 16'hACE1;

    logic       clk_2 = 1'b0;
    logic       rst;
    logic [7:0] btn;
    logic       botton_1, botton_2, botton_3, botton_4;
    logic       botton_5, botton_6, botton_7, botton_8;
    logic [2:0] KEY_COL;
    logic [3:0] KEY_ROW;
    logic       led_1, led_2, led_3, led_4, led_5, led_6, led_7, led_8_s;
    logic [7:0] leds;

    assign {botton_8, botton_7, botton_6, botton_5,
            botton_4, botton_3, botton_2, botton_1} = btn;
    assign leds = {led_8_s, led_7, led_6, led_5, led_4, led_3, led_2, led_1};

    pattern_game_manager #(
        .STEP_ON_CYCLES (ON),
        .STEP_OFF_CYCLES(OFF),
        .RESULT_CYCLES  (RES),
        .MAX_ROUNDS     (MAXR),
        .LFSR_SEED      (SEED)
    ) dut (
        .clk_2   (clk_2),
        .rst     (rst),
        .botton_1(botton_1),
        .botton_2(botton_2),
        .botton_3(botton_3),
        .botton_4(botton_4),
        .botton_5(botton_5),
        .botton_6(botton_6),
        .botton_7(botton_7),
        .botton_8(botton_8),
        .KEY_COL (KEY_COL),
        .KEY_ROW (KEY_ROW),
        .led_1   (led_1),
        .led_2   (led_2),
        .led_3   (led_3),
        .led_4   (led_4),
        .led_5   (led_5),
        .led_6   (led_6),
        .led_7   (led_7),
        .led_8_s (led_8_s)
    );

    always #5 clk_2 = ~clk_2;

    int ntests = 0;
    int nfail  = 0;
    int L;
    int p       [16];
    int obs     [16];
    int p_first [16];

    // Reference LFSR: shift left, new bit = parity of taps 16,14,13,11 (mask B400).
    function automatic logic [15:0] model_step(input logic [15:0] s);
        int ones;
        ones = $countones(s & 16'hB400);
        return {s[14:0], 1'(ones % 2)};
    endfunction

    logic [15:0] m_lfsr;
    always @(posedge clk_2) m_lfsr <= rst ? SEED : model_step(m_lfsr);

    task automatic tick();
        @(posedge clk_2);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] o, input logic [7:0] e);
        ntests++;
        assert (o === e) else begin
            nfail++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    task automatic chk_input();
`ifndef INPUT_ECHO_EN
        chk("input_dark", leds, 8'h00);
`endif
    endtask

    task automatic do_reset();
        rst = 1'b1; btn = 8'h00; KEY_ROW = 4'h0; KEY_COL = 3'h0;
        tick(); chk("rst_leds", leds, 8'h00);
        tick(); tick();
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick(); chk("idle_dark", leds, 8'h00);
        end
    endtask

    // Walks IDLE/DONE -> SELECT -> GEN; returns at the first GEN cycle.
    task automatic select_level(input int lvl, input logic [7:0] prev);
        KEY_ROW = 4'b0001; KEY_COL = 3'b010;
        tick(); chk("key01_ignored", leds, prev);
        KEY_ROW = 4'h0; KEY_COL = 3'h0;
        tick(); chk("key01_ignored", leds, prev);
        KEY_ROW = 4'b0001; KEY_COL = 3'b001;
        tick(); chk("sel_lag", leds, prev);
        for (int i = 0; i < 4; i++) begin
            tick(); chk("select_leds", leds, 8'h07);
        end
        KEY_ROW = 4'b0010; KEY_COL = 3'b001;
        tick(); chk("sel_key10_ignored", leds, 8'h07);
        tick(); chk("sel_key10_ignored", leds, 8'h07);
        KEY_ROW = 4'h0; KEY_COL = 3'h0;
        tick(); chk("select_leds", leds, 8'h07);
        KEY_ROW = 4'b0001; KEY_COL = 3'(1 << (lvl - 1));
        tick(); chk("select_leds", leds, 8'h07);
        KEY_ROW = 4'h0; KEY_COL = 3'h0;
        L = 4 + 4 * lvl;
    endtask

    task automatic gen_capture();
        p[0] = int'(m_lfsr[2:0]);
        for (int k = 1; k < L; k++) begin
            tick(); chk("gen_dark", leds, 8'h00);
            p[k] = int'(m_lfsr[2:0]);
        end
    endtask

    task automatic show_check(input int nsteps);
        tick(); chk("gen_dark", leds, 8'h00);
        for (int k = 0; k < nsteps; k++) begin
            obs[k] = -1;
            for (int i = 0; i < int'(ON); i++) begin
                tick(); chk("show_on", leds, 8'(1 << p[k]));
                if (i == 0)
                    for (int b = 0; b < 8; b++) if (leds[b]) obs[k] = b;
            end
            for (int i = 0; i < int'(OFF); i++) begin
                tick(); chk("show_off", leds, 8'h00);
            end
        end
    endtask

    task automatic press(input int b);
        int hold, gap;
        hold = int'($urandom_range(0, 3));
        gap  = int'($urandom_range(1, 3));
        btn[b] = 1'b1;
        tick(); chk_input();
        for (int i = 0; i < hold; i++) begin
            tick(); chk_input();
        end
        btn = 8'h00;
        for (int i = 0; i < gap; i++) begin
            tick(); chk_input();
        end
    endtask

    // Plays the whole stored pattern; returns on the edge WIN_RND ends.
    task automatic play_round_to_win();
        for (int k = 0; k < L - 1; k++) press(p[k]);
        btn[p[L-1]] = 1'b1;
        tick(); chk_input();
        btn = 8'h00;
        for (int i = 0; i < int'(RES); i++) begin
            tick(); chk("win_all_on", leds, 8'hFF);
        end
    endtask

    // Called on the cycle FAIL was entered.
    task automatic fail_check();
        chk_input();
        for (int i = 0; i < int'(RES); i++) begin
            tick(); chk("fail_blink", leds, (((i / int'(Q)) % 2) == 1) ? 8'hAA : 8'h55);
        end
        tick(); chk("fail_to_idle", leds, 8'h00);
    endtask

    initial begin
        int w;

        // Game 1: level 2, win round 1, wrong button at idx 3 in round 2.
        do_reset();
        select_level(2, 8'h00);
        gen_capture();
        show_check(L);
        for (int k = 0; k < 16; k++) p_first[k] = p[k];
        play_round_to_win();
        gen_capture();
        show_check(L);
        for (int k = 0; k < 3; k++) press(p[k]);
        w = (p[3] + int'($urandom_range(1, 7))) % 8;
        btn[w] = 1'b1;
        tick();
        btn = 8'h00;
        fail_check();

        // Game 2: level 1 through all rounds to DONE, then level 3 double press.
        select_level(1, 8'h00);
        for (int r = 0; r < int'(MAXR); r++) begin
            gen_capture();
            show_check(L);
            play_round_to_win();
        end
        for (int i = 0; i < 10; i++) begin
            tick(); chk("done_steady", leds, 8'hFF);
        end
        select_level(3, 8'hFF);
        gen_capture();
        show_check(L);
        w = (p[0] + int'($urandom_range(1, 7))) % 8;
        btn = 8'(1 << p[0]) | 8'(1 << w);
        tick();
        btn = 8'h00;
        fail_check();

        // Game 3: reset mid-SHOW, then the first pattern must repeat.
        select_level(2, 8'h00);
        gen_capture();
        show_check(3);
        do_reset();
        select_level(2, 8'h00);
        gen_capture();
        show_check(L);
        for (int k = 0; k < L; k++) chk("replay_pattern", 8'(obs[k]), 8'(p_first[k]));

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
